// File: rtl/level_debouncer.sv
// Debounces a synchronized level input.
// The output follows a new level only after it holds for STABLE_TICKS sample ticks.
module level_debouncer #(
    parameter int STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic m_tick,
    output logic curr_level
);

    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ZERO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A level reversal in a wait state wins over a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ZERO: begin
                if (level) begin
                    w_state_nxt = WAIT1;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT1: begin
                if (!level) begin
                    w_state_nxt = ZERO;
                    w_cnt_nxt   = '0;
                end else if (m_tick && (r_cnt == LAST)) begin
                    w_state_nxt = ONE;
                    w_cnt_nxt   = '0;
                end else if (m_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ONE: begin
                if (!level) begin
                    w_state_nxt = WAIT0;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT0: begin
                if (level) begin
                    w_state_nxt = ONE;
                    w_cnt_nxt   = '0;
                end else if (m_tick && (r_cnt == LAST)) begin
                    w_state_nxt = ZERO;
                    w_cnt_nxt   = '0;
                end else if (m_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ZERO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        curr_level = (r_state == ONE) || (r_state == WAIT0);
    end

endmodule

// File: tb/tb_level_debouncer.sv
// Bench for level_debouncer: directed vector table, timed bounce and
// sparse-tick sequences, then random stimulus against a reference model.
module tb_level_debouncer;

    localparam int ST = 3;

    logic clk = 1'b0;
    logic reset;
    logic level;
    logic m_tick;
    logic curr_level;

    int n_tests = 0;
    int n_fail  = 0;

    level_debouncer #(.STABLE_TICKS(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .m_tick    (m_tick),
        .curr_level(curr_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic l;
        logic t;
        logic e;
    } vec_t;

    vec_t vecs[$];

    // Reference: output flips once the opposite level has persisted
    // through ST ticks, the tick on the first differing cycle excluded.
    logic m_out;
    bit   m_pend;
    int   m_ticks;

    task automatic model_step(input logic r, input logic l, input logic t);
        if (!r) begin
            m_out  = 1'b0;
            m_pend = 0;
        end else if (l == m_out) begin
            m_pend = 0;
        end else if (!m_pend) begin
            m_pend  = 1;
            m_ticks = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == ST) begin
                m_out  = l;
                m_pend = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic exp);
        n_tests++;
        if (curr_level !== exp) begin
            n_fail++;
            $display("FAIL %s: curr_level=%b expected=%b at %0t",
                     name, curr_level, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic t);
        reset  = r;
        level  = l;
        m_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic l,
                       input logic t, input logic e);
        vec_t v;
        v.r = r;
        v.l = l;
        v.t = t;
        v.e = e;
        vecs.push_back(v);
    endtask

    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) check("bounce_hold", 1'b0);
    end

    initial begin
        reset  = 1'b0;
        level  = 1'b0;
        m_tick = 1'b0;
        m_out  = 1'b0;
        m_pend = 0;
        m_ticks = 0;

        // reset, clean rise
        add(0, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 1);
        add(1, 1, 1, 1);
        // fall with one-cycle glitch, then full restart
        add(1, 0, 1, 1);
        add(1, 0, 1, 1);
        add(1, 1, 1, 1);
        add(1, 0, 1, 1);
        add(1, 0, 1, 1);
        add(1, 0, 1, 1);
        add(1, 0, 1, 0);
        // reversal on the final tick cycle
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 0, 1, 0);
        add(1, 0, 1, 0);
        // tick held low freezes the wait
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 0, 0);
        add(1, 1, 1, 1);
        // back to zero, then reset mid-WAIT1 at count 2
        add(1, 0, 1, 1);
        add(1, 0, 1, 1);
        add(1, 0, 1, 1);
        add(1, 0, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(0, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 0);
        add(1, 1, 1, 1);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].l, vecs[i].t);
            check($sformatf("vec%0d", i), vecs[i].e);
        end

        // timed bounce from ZERO with a tick every cycle
        step(0, 0, 1);
        step(1, 0, 1);
        mon_en = 1;
        level  = 1'b1;
        #12 level = 1'b0;
        #15 level = 1'b1;
        #10 level = 1'b0;
        #19;
        @(posedge clk);
        #1;
        mon_en = 0;
        check("bounce_end", 1'b0);

        // sparse ticks: one tick every 8 cycles
        step(1, 1, 0);
        check("sparse_entry", 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(1, 1, (k % 8) == 0);
            check($sformatf("sparse_k%0d", k), (k >= 24) ? 1'b1 : 1'b0);
        end

        // random stimulus against the reference model
        step(0, 0, 0);
        model_step(0, 0, 0);
        check("rand_reset", m_out);
        begin
            logic rl;
            logic rr;
            logic rt;
            rl = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                rr = ($urandom_range(0, 79) != 0);
                if ($urandom_range(0, 5) == 0) rl = ~rl;
                rt = ($urandom_range(0, 2) != 0);
                step(rr, rl, rt);
                model_step(rr, rl, rt);
                check("rand", m_out);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/level_debouncer.md
Name: level_debouncer

Overview:
- FSM-based switch/button debouncer. Filters a bouncy asynchronous-origin level input and outputs a clean level.
- A transition is accepted only after the input holds its new value for STABLE_TICKS consecutive sample ticks.
- m_tick is a one-clock-wide sampling strobe from an external prescaler, typically ~10 ms. The block sits between the input synchronizer and the control logic.

Parameters:
- STABLE_TICKS, 3, number of m_tick pulses the new level must persist before curr_level changes (legal range >=1).
- CNT_W, max(1, clog2(STABLE_TICKS)), width of the internal tick counter (derived; not user-set).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk).
- level  input  1  raw bouncy level, already synchronized to clk.
- m_tick  input  1  sample strobe, high for one clk cycle per tick period; may be high every cycle.
- curr_level  output  1  debounced level.

Behaviour:
- Reset: when reset==0 at a rising edge, state<=ZERO, counter<=0, curr_level=0. Reset has priority over all other inputs, including mid-wait.
- State encoding: four states, ZERO, WAIT1, ONE, WAIT0. curr_level is a Moore decode of the state register: 1 in ONE and WAIT0, 0 in ZERO and WAIT1. No combinational path from level or m_tick to curr_level.
- ZERO:
  - level==1 -> WAIT1, counter<=0. A tick in the same cycle is not counted.
  - Otherwise stay.
- WAIT1:
  - level==0 -> ZERO, counter<=0 (bounce rejected; checked before tick).
  - Else if m_tick and counter==STABLE_TICKS-1 -> ONE, counter<=0.
  - Else if m_tick -> counter<=counter+1.
  - Else hold.
- ONE:
  - level==0 -> WAIT0, counter<=0.
  - Otherwise stay.
- WAIT0 (mirror of WAIT1):
  - level==1 -> ONE, counter<=0.
  - Else if m_tick and counter==STABLE_TICKS-1 -> ZERO, counter<=0.
  - Else if m_tick -> counter++.
- Latency: curr_level changes on the clock edge that samples the STABLE_TICKS-th m_tick after the WAIT state is entered. With m_tick high every cycle, that is STABLE_TICKS+1 clk edges after level is first sampled at its new value.
- Glitch rejection: any reversal of level during a WAIT state, even on the final tick cycle, aborts the wait. curr_level then stays unchanged.
- STABLE_TICKS==1: the first m_tick after WAIT entry completes the transition.
- m_tick held low: WAIT states hold indefinitely, counter frozen, curr_level unchanged.
- Counter never exceeds STABLE_TICKS-1; no wrap-around.
- Illegal or unused state encodings recover to ZERO on the next edge.

Test Plan:
- Reset: reset=0 for 1 edge with level=1, m_tick=1 -> curr_level=0 and state ZERO. Release reset -> WAIT1 entered next edge.
- Clean rise: STABLE_TICKS=3, m_tick every cycle, level 0->1 held 100 ns (clk 10 ns) -> curr_level rises exactly 4 edges after level first sampled high, then stays 1.
- Bounce rejection: level high 12 ns, low 15 ns, high 10 ns, low 19 ns (each pulse shorter than 3 ticks) -> curr_level stays 0 throughout.
- Clean fall: from curr_level=1, level 1->0 held -> curr_level falls 4 edges after level first sampled low. A one-cycle high glitch during WAIT0 returns to ONE, and the next fall restarts the count from 0.
- Sparse ticks: m_tick every 8 cycles, level held high -> curr_level rises on the edge of the 3rd tick after WAIT1 entry. No change while m_tick=0.
- Mid-wait reset: assert reset while in WAIT1 with counter=2 -> curr_level=0, counter=0. Full STABLE_TICKS required again after release.
